// File: rtl/mem_access_stage_pkg.sv
// Shared definitions for the memory-access stage: RV32I funct3 codes, FSM states
// and the lane/legality helpers used by the stage and its load extender.
package mem_access_stage_pkg;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   localparam logic [2:0] F3_SB  = 3'b000;
   localparam logic [2:0] F3_SH  = 3'b001;
   localparam logic [2:0] F3_SW  = 3'b010;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_WAIT = 1'b1
   } state_t;

   function automatic logic is_illegal(input logic is_load, input logic [2:0] f3);
      if (is_load) begin
         return !(f3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU});
      end
      return !(f3 inside {F3_SB, F3_SH, F3_SW});
   endfunction

   // funct3[1:0] carries the access size for every legal load and store code
   function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] lo);
      case (f3[1:0])
         2'b01:   return lo[0];
         2'b10:   return lo != 2'b00;
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic [3:0] lane_be(input logic [2:0] f3, input logic [1:0] lo);
      case (f3[1:0])
         2'b00:   return 4'b0001 << lo;
         2'b01:   return 4'b0011 << lo;
         2'b10:   return 4'b1111;
         default: return 4'b0000;
      endcase
   endfunction

   function automatic logic [31:0] lane_wdata(input logic [2:0] f3, input logic [31:0] wd);
      case (f3[1:0])
         2'b00:   return {4{wd[7:0]}};
         2'b01:   return {2{wd[15:0]}};
         2'b10:   return wd;
         default: return '0;
      endcase
   endfunction

endpackage

// File: rtl/mem_access_stage_if.sv
// Data-memory request/response bus between the memory stage (master) and the
// data memory (slave).
interface mem_access_stage_if #(
   parameter int ADDRESS_WIDTH = 32,
   parameter int DATA_WIDTH    = 32
);

   logic                     dmem_req;
   logic                     dmem_we;
   logic [ADDRESS_WIDTH-1:0] dmem_addr;
   logic [3:0]               dmem_be;
   logic [DATA_WIDTH-1:0]    dmem_wdata;
   logic                     dmem_ready;
   logic [DATA_WIDTH-1:0]    dmem_rdata;

   modport master (
      output dmem_req,
      output dmem_we,
      output dmem_addr,
      output dmem_be,
      output dmem_wdata,
      input  dmem_ready,
      input  dmem_rdata
   );

   modport slave (
      input  dmem_req,
      input  dmem_we,
      input  dmem_addr,
      input  dmem_be,
      input  dmem_wdata,
      output dmem_ready,
      output dmem_rdata
   );

endinterface

// File: rtl/mem_access_stage_load_extend.sv
// Load lane select and sign/zero extension of a 32-bit memory word.
module mem_access_stage_load_extend #(
   parameter int DATA_WIDTH = 32
) (
   input  logic [2:0]            funct3,
   input  logic [1:0]            addr_lo,
   input  logic [DATA_WIDTH-1:0] rdata,
   output logic [DATA_WIDTH-1:0] data
);

   import mem_access_stage_pkg::*;

   logic [7:0]  lane_b;
   logic [15:0] lane_h;

   always_comb begin
      lane_b = rdata[{addr_lo, 3'b000} +: 8];
      lane_h = rdata[{addr_lo[1], 4'b0000} +: 16];
      data   = '0;
      case (funct3)
         F3_LB:   data = {{24{lane_b[7]}}, lane_b};
         F3_LH:   data = {{16{lane_h[15]}}, lane_h};
         F3_LW:   data = rdata;
         F3_LBU:  data = {24'd0, lane_b};
         F3_LHU:  data = {16'd0, lane_h};
         default: data = '0;
      endcase
   end

endmodule

// File: rtl/mem_access_stage.sv
// Memory stage of the barrel pipeline: issues the data-memory request, stalls
// while the memory is busy, extends load data and flags faults and bus timeouts.
module mem_access_stage #(
   parameter  int ADDRESS_WIDTH  = 32,
   parameter  int DATA_WIDTH     = 32,
   parameter  int NUM_THREADS    = 8,
   parameter  int TIMEOUT_CYCLES = 16,
   localparam int BITS_THREADS   = $clog2(NUM_THREADS)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     mem_read_m,
   input  logic                     mem_write_m,
   input  logic [2:0]               funct3_m,
   input  logic [ADDRESS_WIDTH-1:0] alu_result_m,
   input  logic [DATA_WIDTH-1:0]    write_data_m,
   input  logic [BITS_THREADS-1:0]  tid_m,
   mem_access_stage_if.master       dmem,
   output logic [DATA_WIDTH-1:0]    read_data_m,
   output logic                     stall_m,
   output logic                     fault_m,
   output logic                     bus_err_m,
   output logic [BITS_THREADS-1:0]  err_tid_m
);

   import mem_access_stage_pkg::*;

   localparam int                WCNT_W    = $clog2(TIMEOUT_CYCLES);
   localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(TIMEOUT_CYCLES - 1);

   state_t                  state;
   state_t                  state_nxt;
   logic [WCNT_W-1:0]       wcnt;
   logic [WCNT_W-1:0]       wcnt_nxt;
   logic [BITS_THREADS-1:0] tid_q;

   logic                    access;
   logic                    is_load;
   logic                    is_store;
   logic                    acc_bad;
   logic                    legal;
   logic                    wcnt_last;

   logic                    req_c;
   logic                    stall_c;
   logic                    fault_c;
   logic                    timeout;
   logic                    complete;
   logic [DATA_WIDTH-1:0]   ext_data;

   // A slot with both read and write set is handled as a load
   assign access    = mem_read_m | mem_write_m;
   assign is_load   = mem_read_m;
   assign is_store  = mem_write_m & ~mem_read_m;
   assign acc_bad   = is_illegal(is_load, funct3_m) | is_misaligned(funct3_m, alu_result_m[1:0]);
   assign legal     = access & ~acc_bad;
   assign wcnt_last = (wcnt == WCNT_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         wcnt      <= '0;
         bus_err_m <= 1'b0;
         tid_q     <= '0;
      end else begin
         state     <= state_nxt;
         wcnt      <= wcnt_nxt;
         bus_err_m <= timeout;
         if (state == S_IDLE && state_nxt == S_WAIT) begin
            tid_q <= tid_m;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      wcnt_nxt  = wcnt;
      case (state)
         S_IDLE: begin
            if (legal && !dmem.dmem_ready) begin
               state_nxt = S_WAIT;
               wcnt_nxt  = WCNT_W'(1);
            end
         end
         S_WAIT: begin
            if (dmem.dmem_ready || wcnt_last) begin
               state_nxt = S_IDLE;
               wcnt_nxt  = '0;
            end else begin
               wcnt_nxt = wcnt + 1'b1;
            end
         end
         default: begin
            state_nxt = S_IDLE;
            wcnt_nxt  = '0;
         end
      endcase
   end

   // Faults are only judged in IDLE; a WAIT slot is frozen and already legal
   always_comb begin
      req_c    = 1'b0;
      stall_c  = 1'b0;
      fault_c  = 1'b0;
      timeout  = 1'b0;
      complete = 1'b0;
      case (state)
         S_IDLE: begin
            fault_c  = access & acc_bad;
            req_c    = legal;
            stall_c  = legal & ~dmem.dmem_ready;
            complete = legal & dmem.dmem_ready;
         end
         S_WAIT: begin
            timeout  = ~dmem.dmem_ready & wcnt_last;
            req_c    = ~timeout;
            stall_c  = ~dmem.dmem_ready & ~wcnt_last;
            complete = dmem.dmem_ready;
         end
         default: ;
      endcase
   end

   // Gating with rst_n lets a reset in WAIT drop the request without a clock
   assign dmem.dmem_req   = req_c & rst_n;
   assign stall_m         = stall_c & rst_n;
   assign fault_m         = fault_c & rst_n;

   assign dmem.dmem_we    = is_store;
   assign dmem.dmem_addr  = {alu_result_m[ADDRESS_WIDTH-1:2], 2'b00};
   assign dmem.dmem_be    = access ? lane_be(funct3_m, alu_result_m[1:0]) : 4'b0000;
   assign dmem.dmem_wdata = is_store ? lane_wdata(funct3_m, write_data_m) : '0;

   mem_access_stage_load_extend #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_load_extend (
      .funct3  (funct3_m),
      .addr_lo (alu_result_m[1:0]),
      .rdata   (dmem.dmem_rdata),
      .data    (ext_data)
   );

   assign read_data_m = (complete && is_load) ? ext_data : '0;
   assign err_tid_m   = bus_err_m ? tid_q : (fault_m ? tid_m : tid_q);

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Memory stage of the barrel pipeline, between the EX/MEM register and the MEM/WB register.
- Turns the ALU address and store data into a word-aligned data-memory request with byte enables, using a req/ready handshake.
- Sign- or zero-extends load data into read_data_m.
- Raises stall_m while the memory is busy. stall_m drives the MEM/WB register enable (enable high = hold) and all upstream stage registers.
- Flags misaligned or illegal accesses and bus timeouts, tagged with the issuing thread ID.

Parameters:
- ADDRESS_WIDTH, 32, byte address width.
- DATA_WIDTH, 32, data width. Only 32 is supported.
- NUM_THREADS, 8, hardware threads. BITS_THREADS = $clog2(NUM_THREADS).
- TIMEOUT_CYCLES, 16, maximum wait cycles before a bus error. Must be >= 2.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- mem_read_m  in  1  load in the MEM slot
- mem_write_m  in  1  store in the MEM slot
- funct3_m  in  3  RV32I width/sign code
- alu_result_m  in  ADDRESS_WIDTH  effective byte address
- write_data_m  in  DATA_WIDTH  store source (rs2)
- tid_m  in  BITS_THREADS  thread of the MEM slot
- dmem_req  out  1  request valid
- dmem_we  out  1  1 = write
- dmem_addr  out  ADDRESS_WIDTH  word address, bits [1:0] = 0
- dmem_be  out  4  byte enables
- dmem_wdata  out  DATA_WIDTH  lane-replicated store data
- dmem_ready  in  1  request accepted/completed this cycle
- dmem_rdata  in  DATA_WIDTH  read data, valid when dmem_ready
- read_data_m  out  DATA_WIDTH  extended load data, to the MEM/WB register
- stall_m  out  1  hold the pipeline
- fault_m  out  1  misaligned or illegal access, one-cycle pulse
- bus_err_m  out  1  timeout, one-cycle registered pulse
- err_tid_m  out  BITS_THREADS  thread associated with fault_m or bus_err_m

Behaviour:
- State machine: IDLE and WAIT, plus a wait counter wcnt of $clog2(TIMEOUT_CYCLES) bits.
- Reset (rst_n low, asynchronous):
  - state = IDLE, wcnt = 0, bus_err_m = 0, err_tid register = 0.
  - dmem_req, stall_m and fault_m are forced to 0.
- access = mem_read_m | mem_write_m. If both are set, treat it as a load.
- Illegal codes:
  - Load funct3 011, 110 or 111 is illegal.
  - Store funct3 other than 000, 001 or 010 is illegal.
- Misaligned:
  - Halfword access with addr[0] = 1.
  - Word access with addr[1:0] != 0.
- Faulting access (misaligned or illegal):
  - Combinational fault_m = 1 and err_tid_m = tid_m.
  - No dmem_req is issued, stall_m = 0, read_data_m = 0. State stays IDLE.
- Byte enables and write data:
  - Byte: be = 0001 << addr[1:0]; wdata = four copies of the low byte.
  - Half: be = 0011 << addr[1:0]; wdata = two copies of the low half.
  - Word: be = 1111; wdata = write_data_m.
  - For loads, be uses the same encoding and wdata = 0.
- dmem_addr = {alu_result_m[ADDRESS_WIDTH-1:2], 2'b00}. dmem_we = mem_write_m & ~mem_read_m.
- IDLE with a legal access:
  - dmem_req = 1 combinationally.
  - If dmem_ready is 1 in the same cycle: zero-wait completion, stall_m = 0, stay IDLE.
  - Otherwise: stall_m = 1, go to WAIT, wcnt = 1.
- WAIT:
  - dmem_req = 1, stall_m = 1. Request fields are held stable because the pipeline is frozen.
  - dmem_ready = 1: stall_m = 0 that cycle, return to IDLE, wcnt = 0.
  - dmem_ready = 0 and wcnt == TIMEOUT_CYCLES-1:
    - dmem_req = 0, stall_m = 0, read_data_m = 0 that cycle.
    - Go to IDLE.
    - bus_err_m = 1 for exactly the next cycle, with err_tid_m = the captured tid.
  - Otherwise wcnt increments.
- Load extraction, on the completion cycle only:
  - Select the byte or half by addr[1:0] or addr[1].
  - lb/lh sign-extend; lbu/lhu zero-extend; lw passes through.
  - read_data_m = 0 for stores, for non-access slots and on any cycle without dmem_ready.
- Simultaneous events:
  - dmem_ready on the timeout cycle means completion wins; no bus_err_m.
  - fault_m and bus_err_m cannot coincide because fault is only evaluated in IDLE. err_tid_m prioritises bus_err_m.
- Reset in WAIT aborts the request immediately. No error pulse is produced.
- All threads stall together while in WAIT (barrel pipeline, single MEM slot).

Decomposition:
- Shared package/header holds:
  - funct3 load codes: LB = 000, LH = 001, LW = 010, LBU = 100, LHU = 101.
  - funct3 store codes: SB = 000, SH = 001, SW = 010.
  - State encodings: S_IDLE = 0, S_WAIT = 1.
- Natural sub-module: load_extend (combinational lane select and sign/zero extend), reused by any future cached LSU.

Test Plan:
- Zero-wait lw: addr 0x104, ready high, rdata 0xDEADBEEF -> dmem_addr 0x104, be 1111, read_data_m 0xDEADBEEF, stall_m never 1.
- lb at 0x203, rdata 0x80112233, ready after 3 cycles -> stall_m high for 3 cycles, be 1000, read_data_m 0xFFFFFF80 on the ready cycle. The same access as lbu gives 0x00000080.
- sh at 0x12 with write_data 0x0000ABCD -> dmem_we 1, addr 0x10, be 1100, wdata 0xABCDABCD.
- Misaligned lw at 0x106, tid 5 -> fault_m 1, err_tid_m 5, dmem_req 0, stall_m 0.
- Timeout: sw, ready held low, TIMEOUT_CYCLES 16, tid 3 -> stall_m high for 15 cycles, drops on the 16th; bus_err_m pulses the next cycle with err_tid_m 3. A variant with ready on the 16th cycle gives no bus_err_m.
- rst_n pulled low during WAIT -> dmem_req and stall_m drop to 0 asynchronously; after release, state is IDLE and a new lw completes normally.
